// File: rtl/i2c_arbiter_if.sv
// Bundle between the requesters, the arbiter and the single-byte I2C master.
// The master modport is the arbiter's view; slave is the environment's view.
interface i2c_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_rw;
  logic [7*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic                 err;
  logic [7:0]           rd_data;
  logic                 m_start;
  logic                 m_rw;
  logic [6:0]           m_addr;
  logic [7:0]           m_wdata;
  logic                 m_busy;
  logic [7:0]           m_rdata;

  modport master (
    input  req, req_rw, req_addr, req_wdata, m_busy, m_rdata,
    output gnt, done, err, rd_data, m_start, m_rw, m_addr, m_wdata
  );

  modport slave (
    output req, req_rw, req_addr, req_wdata, m_busy, m_rdata,
    input  gnt, done, err, rd_data, m_start, m_rw, m_addr, m_wdata
  );
endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one single-byte I2C master between NUM_REQ
// requesters, with a per-transaction watchdog.
//
// state     | meaning
// IDLE      | no owner; arbitrate among pending requests
// ISSUE     | m_start held high until the master reports busy
// WAIT_DONE | master busy; wait for it to fall
// FINISH    | one-cycle done (and err on timeout) pulse to the owner
module i2c_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 65535
) (
  input logic           clk,
  input logic           rst,
  i2c_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, FINISH} state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]   last, cand, win_idx;
  logic               win_found;
  logic               sel_rw;
  logic [6:0]         sel_addr;
  logic [7:0]         sel_wdata;
  logic [15:0]        wdog;
  logic               wdog_hit;

  logic [NUM_REQ-1:0] gnt, done;
  logic               err, m_start, m_rw;
  logic [6:0]         m_addr;
  logic [7:0]         m_wdata, rd_data;

  assign wdog_hit = (wdog == 16'(TIMEOUT - 1));

  // Search upward from the requester after the last owner, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last) + k) % NUM_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_rw    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_rw    = bus.req_rw[i];
        sel_addr  = bus.req_addr[i*7 +: 7];
        sel_wdata = bus.req_wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (win_found) state_nxt = ISSUE;
      ISSUE:     if (wdog_hit || bus.m_busy) state_nxt = wdog_hit ? FINISH : WAIT_DONE;
      WAIT_DONE: if (wdog_hit || !bus.m_busy) state_nxt = FINISH;
      FINISH:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // gnt already holds the owner one-hot, so it doubles as the done vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt     <= '0;
      done    <= '0;
      err     <= 1'b0;
      m_start <= 1'b0;
      m_rw    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      rd_data <= '0;
      wdog    <= '0;
      last    <= IDX_W'(NUM_REQ - 1);
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt     <= NUM_REQ'(1) << win_idx;
            m_start <= 1'b1;
            m_rw    <= sel_rw;
            m_addr  <= sel_addr;
            m_wdata <= sel_wdata;
            wdog    <= '0;
          end
        end
        ISSUE: begin
          wdog <= wdog + 16'd1;
          if (wdog_hit) begin
            m_start <= 1'b0;
            done    <= gnt;
            err     <= 1'b1;
          end else if (bus.m_busy) begin
            m_start <= 1'b0;
          end
        end
        WAIT_DONE: begin
          wdog <= wdog + 16'd1;
          if (wdog_hit) begin
            done <= gnt;
            err  <= 1'b1;
          end else if (!bus.m_busy) begin
            if (m_rw) rd_data <= bus.m_rdata;
            done <= gnt;
          end
        end
        FINISH: begin
          for (int i = 0; i < NUM_REQ; i++)
            if (gnt[i]) last <= IDX_W'(i);
          gnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt     = gnt;
  assign bus.done    = done;
  assign bus.err     = err;
  assign bus.rd_data = rd_data;
  assign bus.m_start = m_start;
  assign bus.m_rw    = m_rw;
  assign bus.m_addr  = m_addr;
  assign bus.m_wdata = m_wdata;
endmodule
